// File: rtl/ita_softmax_div_sched_if.sv
// Operand stream, divider pool and accumulator write-port bundle for the
// softmax divider scheduler. Signal suffixes are relative to the scheduler.
interface ita_softmax_div_sched_if #(
    parameter int unsigned NumDiv    = 4,
    parameter int unsigned DataWidth = 24,
    parameter int unsigned OupWidth  = 24,
    parameter int unsigned AddrWidth = 6
);
    localparam int unsigned OutW = $clog2(NumDiv + 1);

    logic                             inp_valid_i;
    logic                             inp_ready_o;
    logic [DataWidth-1:0]             inp_data_i;
    logic [NumDiv-1:0]                div_valid_o;
    logic [NumDiv-1:0]                div_ready_i;
    logic [DataWidth-1:0]             div_data_o;
    logic [NumDiv-1:0]                div_valid_i;
    logic [NumDiv-1:0]                div_ready_o;
    logic [NumDiv-1:0][OupWidth-1:0]  div_oup_i;
    logic                             wr_en_o;
    logic [AddrWidth-1:0]             wr_addr_o;
    logic [DataWidth-1:0]             wr_data_o;
    logic                             row_done_o;
    logic                             busy_o;
    logic [OutW-1:0]                  outstanding_o;

    modport master (
        input  inp_valid_i, inp_data_i, div_ready_i, div_valid_i, div_oup_i,
        output inp_ready_o, div_valid_o, div_data_o, div_ready_o,
               wr_en_o, wr_addr_o, wr_data_o, row_done_o, busy_o, outstanding_o
    );

    modport slave (
        output inp_valid_i, inp_data_i, div_ready_i, div_valid_i, div_oup_i,
        input  inp_ready_o, div_valid_o, div_data_o, div_ready_o,
               wr_en_o, wr_addr_o, wr_data_o, row_done_o, busy_o, outstanding_o
    );
endinterface

// File: rtl/ita_softmax_div_sched.sv
// Round-robin dispatch of softmax row exp-sums to a divider pool; quotients are
// collected in issue order and written to the accumulator at incrementing addresses.
module ita_softmax_div_sched #(
    parameter int unsigned NumDiv    = 4,
    parameter int unsigned DataWidth = 24,
    parameter int unsigned OupWidth  = 24,
    parameter int unsigned RowLen    = 64,
    parameter int unsigned AddrWidth = 6
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    ita_softmax_div_sched_if.master bus
);
    localparam int unsigned PtrW = $clog2(NumDiv);
    localparam int unsigned OutW = $clog2(NumDiv + 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    logic                 clear;
    logic                 has_room;
    logic                 inp_ready;
    logic                 issue;
    logic                 collect;
    logic [NumDiv-1:0]    div_valid;
    logic [NumDiv-1:0]    div_ready;

    logic [PtrW-1:0]      issue_ptr_q, issue_ptr_d;
    logic [PtrW-1:0]      collect_ptr_q, collect_ptr_d;
    logic [OutW-1:0]      outstanding_q, outstanding_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [AddrWidth-1:0] issue_cnt_q, issue_cnt_d;
    logic [AddrWidth-1:0] wr_addr_q, wr_addr_d;
    logic [DataWidth-1:0] wr_data_q, wr_data_d;
    logic                 wr_en_q, wr_en_d;
    logic                 row_done_q, row_done_d;
    logic [1:0]           state_q, state_d;

    assign clear     = !rst_ni || flush_i;
    assign has_room  = !clear && (outstanding_q < OutW'(NumDiv));
    assign inp_ready = has_room && bus.div_ready_i[issue_ptr_q];
    assign issue     = inp_ready && bus.inp_valid_i;
    assign collect   = !clear && bus.div_valid_i[collect_ptr_q] && (outstanding_q != '0);

    always_comb begin
        div_valid = '0;
        div_ready = '0;
        // Valid is withheld when the pool is full so no divider accepts an uncounted operand.
        if (has_room) div_valid[issue_ptr_q] = bus.inp_valid_i;
        if (!clear)   div_ready[collect_ptr_q] = 1'b1;
    end

    assign bus.inp_ready_o   = inp_ready;
    assign bus.div_valid_o   = div_valid;
    assign bus.div_ready_o   = div_ready;
    assign bus.div_data_o    = bus.inp_data_i;
    assign bus.wr_en_o       = wr_en_q;
    assign bus.wr_addr_o     = wr_addr_q;
    assign bus.wr_data_o     = wr_data_q;
    assign bus.row_done_o    = row_done_q;
    assign bus.busy_o        = (state_q != StIdle);
    assign bus.outstanding_o = outstanding_q;

    always_comb begin
        issue_ptr_d   = issue_ptr_q;
        collect_ptr_d = collect_ptr_q;
        outstanding_d = outstanding_q;
        issue_cnt_d   = issue_cnt_q;
        addr_d        = addr_q;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        wr_en_d       = collect;
        row_done_d    = 1'b0;
        state_d       = state_q;

        if (issue) begin
            issue_ptr_d = (issue_ptr_q == PtrW'(NumDiv - 1)) ? '0 : issue_ptr_q + 1'b1;
            issue_cnt_d = (issue_cnt_q == AddrWidth'(RowLen - 1)) ? '0 : issue_cnt_q + 1'b1;
        end

        case ({issue, collect})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase

        if (collect) begin
            collect_ptr_d = (collect_ptr_q == PtrW'(NumDiv - 1)) ? '0 : collect_ptr_q + 1'b1;
            wr_addr_d     = addr_q;
            wr_data_d     = DataWidth'(bus.div_oup_i[collect_ptr_q]);
            row_done_d    = (addr_q == AddrWidth'(RowLen - 1));
            addr_d        = row_done_d ? '0 : addr_q + 1'b1;
        end

        case (state_q)
            StIdle, StRun: begin
                if (issue) state_d = (issue_cnt_q == AddrWidth'(RowLen - 1)) ? StDrain : StRun;
            end
            StDrain: begin
                // Operands of the next row may already be in flight when this row retires.
                if (row_done_q) state_d = (issue || issue_cnt_q != '0) ? StRun : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            issue_ptr_q   <= '0;
            collect_ptr_q <= '0;
            outstanding_q <= '0;
            issue_cnt_q   <= '0;
            addr_q        <= '0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            wr_en_q       <= 1'b0;
            row_done_q    <= 1'b0;
            state_q       <= StIdle;
        end else begin
            issue_ptr_q   <= issue_ptr_d;
            collect_ptr_q <= collect_ptr_d;
            outstanding_q <= outstanding_d;
            issue_cnt_q   <= issue_cnt_d;
            addr_q        <= addr_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            wr_en_q       <= wr_en_d;
            row_done_q    <= row_done_d;
            state_q       <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && !flush_i) begin
            assert (!(bus.div_valid_i[collect_ptr_q] && outstanding_q == '0))
                else $error("divider result presented with nothing outstanding");
        end
    end
endmodule

// File: tb/tb_ita_softmax_div_sched.sv
// Directed bench for ita_softmax_div_sched: reset, full row, ordering,
// backpressure, issue/collect collision and mid-row flush.
module tb_ita_softmax_div_sched;
    localparam int unsigned NumDiv    = 4;
    localparam int unsigned DataWidth = 24;
    localparam int unsigned OupWidth  = 24;
    localparam int unsigned RowLen    = 64;
    localparam int unsigned AddrWidth = 6;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic flush_i = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ita_softmax_div_sched_if #(
        .NumDiv(NumDiv), .DataWidth(DataWidth), .OupWidth(OupWidth), .AddrWidth(AddrWidth)
    ) bus ();

    ita_softmax_div_sched #(
        .NumDiv(NumDiv), .DataWidth(DataWidth), .OupWidth(OupWidth),
        .RowLen(RowLen), .AddrWidth(AddrWidth)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .bus(bus)
    );

    bit               use_mdl = 1'b0;
    logic [3:0]       man_ready = '1;
    logic [3:0]       man_valid = '0;
    logic [3:0][23:0] man_oup = '0;
    logic [3:0]       mdl_full = '0;
    logic [3:0]       mdl_valid;
    logic [3:0][23:0] mdl_res = '0;
    int               mdl_cnt [4];

    // Ideal dividers: quotient = operand >> 1, valid 8 cycles after acceptance.
    always @* begin
        for (int i = 0; i < 4; i++) mdl_valid[i] = mdl_full[i] && (mdl_cnt[i] == 0);
    end

    always @(posedge clk) begin
        if (!rst_ni || flush_i) begin
            mdl_full <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (mdl_full[i]) begin
                    if (mdl_cnt[i] > 0) mdl_cnt[i] <= mdl_cnt[i] - 1;
                    else if (bus.div_ready_o[i]) mdl_full[i] <= 1'b0;
                end else if (bus.div_valid_o[i]) begin
                    mdl_full[i] <= 1'b1;
                    mdl_cnt[i]  <= 7;
                    mdl_res[i]  <= bus.div_data_o >> 1;
                end
            end
        end
    end

    assign bus.div_ready_i = use_mdl ? ~mdl_full : man_ready;
    assign bus.div_valid_i = use_mdl ? mdl_valid : man_valid;
    assign bus.div_oup_i   = use_mdl ? mdl_res   : man_oup;

    task automatic do_reset();
        @(negedge clk);
        rst_ni = 1'b0; flush_i = 1'b0; use_mdl = 1'b0;
        man_ready = '1; man_valid = '0; man_oup = '0;
        bus.inp_valid_i = 1'b0; bus.inp_data_i = '0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_ni = 1'b0; use_mdl = 1'b0; man_ready = '1; man_valid = '0;
        bus.inp_valid_i = 1'b1; bus.inp_data_i = 24'h123456;
        repeat (3) @(negedge clk);
        checks++; if (bus.inp_ready_o !== 1'b0) begin failures++; $display("FAIL rst_inp_ready got=%0h exp=0", bus.inp_ready_o); end
        checks++; if (bus.div_valid_o !== 4'h0) begin failures++; $display("FAIL rst_div_valid got=%0h exp=0", bus.div_valid_o); end
        checks++; if (bus.div_ready_o !== 4'h0) begin failures++; $display("FAIL rst_div_ready got=%0h exp=0", bus.div_ready_o); end
        checks++; if (bus.wr_en_o !== 1'b0) begin failures++; $display("FAIL rst_wr_en got=%0h exp=0", bus.wr_en_o); end
        checks++; if (bus.wr_addr_o !== 6'd0) begin failures++; $display("FAIL rst_wr_addr got=%0h exp=0", bus.wr_addr_o); end
        checks++; if (bus.wr_data_o !== 24'd0) begin failures++; $display("FAIL rst_wr_data got=%0h exp=0", bus.wr_data_o); end
        checks++; if (bus.row_done_o !== 1'b0) begin failures++; $display("FAIL rst_row_done got=%0h exp=0", bus.row_done_o); end
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0h exp=0", bus.busy_o); end
        checks++; if (bus.outstanding_o !== 3'd0) begin failures++; $display("FAIL rst_outstanding got=%0h exp=0", bus.outstanding_o); end
        rst_ni = 1'b1;
        #1;
        checks++; if (bus.inp_ready_o !== 1'b1) begin failures++; $display("FAIL rel_inp_ready got=%0h exp=1", bus.inp_ready_o); end
        checks++; if (bus.div_valid_o !== 4'b0001) begin failures++; $display("FAIL rel_div_valid got=%0h exp=1", bus.div_valid_o); end
        checks++; if (bus.div_ready_o !== 4'b0001) begin failures++; $display("FAIL rel_div_ready got=%0h exp=1", bus.div_ready_o); end
        bus.inp_valid_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.outstanding_o !== 3'd0) begin failures++; $display("FAIL rel_outstanding got=%0h exp=0", bus.outstanding_o); end
    endtask

    task automatic test_single_row();
        int sent = 0, wrs = 0, dones = 0, max_out = 0, got = 0;
        do_reset();
        use_mdl = 1'b1;
        for (int cyc = 0; cyc < 2000 && wrs < 64; cyc++) begin
            @(negedge clk);
            if (bus.row_done_o === 1'b1) begin
                dones++;
                checks++; if (wrs !== 63) begin failures++; $display("FAIL row_done_pos got=%0d exp=63", wrs); end
            end
            if (bus.wr_en_o === 1'b1) begin
                checks++; if (bus.wr_addr_o !== 6'(wrs)) begin failures++; $display("FAIL row_addr got=%0d exp=%0d", bus.wr_addr_o, wrs); end
                checks++; if (bus.wr_data_o !== 24'(wrs * 128)) begin failures++; $display("FAIL row_data got=%0h exp=%0h", bus.wr_data_o, wrs * 128); end
                if (wrs == 10) begin
                    checks++; if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL row_busy got=%0h exp=1", bus.busy_o); end
                end
                wrs++;
            end
            if (int'(bus.outstanding_o) > max_out) max_out = int'(bus.outstanding_o);
            bus.inp_valid_i = (sent < 64);
            bus.inp_data_i  = 24'(sent * 256);
            #1;
            if (bus.inp_valid_i && bus.inp_ready_o) sent++;
        end
        bus.inp_valid_i = 1'b0;
        checks++; if (wrs !== 64) begin failures++; $display("FAIL row_write_count got=%0d exp=64", wrs); end
        checks++; if (dones !== 1) begin failures++; $display("FAIL row_done_count got=%0d exp=1", dones); end
        checks++; if (max_out > 4) begin failures++; $display("FAIL row_max_outstanding got=%0d exp<=4", max_out); end
        repeat (2) @(negedge clk);
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL row_idle got=%0h exp=0", bus.busy_o); end
        bus.inp_valid_i = 1'b1; bus.inp_data_i = 24'h000100;
        @(negedge clk);
        bus.inp_valid_i = 1'b0;
        checks++; if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL wrap_busy got=%0h exp=1", bus.busy_o); end
        for (int cyc = 0; cyc < 40 && got == 0; cyc++) begin
            @(negedge clk);
            if (bus.wr_en_o === 1'b1) begin
                got = 1;
                checks++; if (bus.wr_addr_o !== 6'd0) begin failures++; $display("FAIL wrap_addr got=%0d exp=0", bus.wr_addr_o); end
                checks++; if (bus.wr_data_o !== 24'h80) begin failures++; $display("FAIL wrap_data got=%0h exp=80", bus.wr_data_o); end
            end
        end
        checks++; if (got !== 1) begin failures++; $display("FAIL wrap_timeout got=%0d exp=1", got); end
    endtask

    task automatic test_out_of_order();
        do_reset();
        bus.inp_valid_i = 1'b1; bus.inp_data_i = 24'h000111;
        #1;
        checks++; if (bus.div_valid_o !== 4'b0001) begin failures++; $display("FAIL ooo_issue0 got=%0h exp=1", bus.div_valid_o); end
        @(negedge clk);
        bus.inp_data_i = 24'h000222;
        #1;
        checks++; if (bus.div_valid_o !== 4'b0010) begin failures++; $display("FAIL ooo_issue1 got=%0h exp=2", bus.div_valid_o); end
        @(negedge clk);
        bus.inp_valid_i = 1'b0;
        checks++; if (bus.outstanding_o !== 3'd2) begin failures++; $display("FAIL ooo_outstanding got=%0d exp=2", bus.outstanding_o); end
        man_valid = 4'b0010; man_oup[1] = 24'h00000B;
        @(negedge clk);
        checks++; if (bus.wr_en_o !== 1'b0) begin failures++; $display("FAIL ooo_hold got=%0h exp=0", bus.wr_en_o); end
        checks++; if (bus.div_ready_o !== 4'b0001) begin failures++; $display("FAIL ooo_collect_ptr got=%0h exp=1", bus.div_ready_o); end
        man_valid = 4'b0011; man_oup[0] = 24'h00000A;
        @(negedge clk);
        man_valid = 4'b0010;
        checks++; if (bus.wr_en_o !== 1'b1) begin failures++; $display("FAIL ooo_wr0_en got=%0h exp=1", bus.wr_en_o); end
        checks++; if (bus.wr_addr_o !== 6'd0) begin failures++; $display("FAIL ooo_wr0_addr got=%0d exp=0", bus.wr_addr_o); end
        checks++; if (bus.wr_data_o !== 24'h0A) begin failures++; $display("FAIL ooo_wr0_data got=%0h exp=a", bus.wr_data_o); end
        @(negedge clk);
        man_valid = 4'b0000;
        checks++; if (bus.wr_en_o !== 1'b1) begin failures++; $display("FAIL ooo_wr1_en got=%0h exp=1", bus.wr_en_o); end
        checks++; if (bus.wr_addr_o !== 6'd1) begin failures++; $display("FAIL ooo_wr1_addr got=%0d exp=1", bus.wr_addr_o); end
        checks++; if (bus.wr_data_o !== 24'h0B) begin failures++; $display("FAIL ooo_wr1_data got=%0h exp=b", bus.wr_data_o); end
        checks++; if (bus.outstanding_o !== 3'd0) begin failures++; $display("FAIL ooo_drained got=%0d exp=0", bus.outstanding_o); end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.inp_valid_i = 1'b1; bus.inp_data_i = 24'h000AAA;
        @(negedge clk);
        man_ready = 4'b1101; bus.inp_data_i = 24'h000BBB;
        #1;
        checks++; if (bus.inp_ready_o !== 1'b0) begin failures++; $display("FAIL bp_blocked got=%0h exp=0", bus.inp_ready_o); end
        checks++; if (bus.div_valid_o !== 4'b0010) begin failures++; $display("FAIL bp_no_skip got=%0h exp=2", bus.div_valid_o); end
        repeat (2) @(negedge clk);
        checks++; if (bus.outstanding_o !== 3'd1) begin failures++; $display("FAIL bp_outstanding got=%0d exp=1", bus.outstanding_o); end
        man_ready = 4'b1111;
        #1;
        checks++; if (bus.inp_ready_o !== 1'b1) begin failures++; $display("FAIL bp_resume got=%0h exp=1", bus.inp_ready_o); end
        checks++; if (bus.div_valid_o !== 4'b0010) begin failures++; $display("FAIL bp_same_div got=%0h exp=2", bus.div_valid_o); end
        @(negedge clk);
        checks++; if (bus.outstanding_o !== 3'd2) begin failures++; $display("FAIL bp_issued got=%0d exp=2", bus.outstanding_o); end
        #1;
        checks++; if (bus.div_valid_o !== 4'b0100) begin failures++; $display("FAIL bp_next_div got=%0h exp=4", bus.div_valid_o); end
        bus.inp_valid_i = 1'b0;
    endtask

    task automatic test_issue_collect_same_cycle();
        do_reset();
        bus.inp_valid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.inp_data_i = 24'(k + 1);
            @(negedge clk);
        end
        checks++; if (bus.outstanding_o !== 3'd4) begin failures++; $display("FAIL col_full got=%0d exp=4", bus.outstanding_o); end
        man_valid = 4'b0001; man_oup[0] = 24'h0000C0; bus.inp_data_i = 24'h000005;
        #1;
        checks++; if (bus.inp_ready_o !== 1'b0) begin failures++; $display("FAIL col_issue_blocked got=%0h exp=0", bus.inp_ready_o); end
        checks++; if (bus.div_valid_o !== 4'b0000) begin failures++; $display("FAIL col_valid_blocked got=%0h exp=0", bus.div_valid_o); end
        @(negedge clk);
        man_valid = 4'b0000;
        checks++; if (bus.outstanding_o !== 3'd3) begin failures++; $display("FAIL col_after got=%0d exp=3", bus.outstanding_o); end
        checks++; if (bus.wr_data_o !== 24'h0000C0) begin failures++; $display("FAIL col_wr_data got=%0h exp=c0", bus.wr_data_o); end
        #1;
        checks++; if (bus.inp_ready_o !== 1'b1) begin failures++; $display("FAIL col_issue_resume got=%0h exp=1", bus.inp_ready_o); end
        checks++; if (bus.div_valid_o !== 4'b0001) begin failures++; $display("FAIL col_ptr_wrap got=%0h exp=1", bus.div_valid_o); end
        @(negedge clk);
        bus.inp_valid_i = 1'b0;
        checks++; if (bus.outstanding_o !== 3'd4) begin failures++; $display("FAIL col_reissued got=%0d exp=4", bus.outstanding_o); end
    endtask

    task automatic test_flush();
        int sent = 0, wrs = 0;
        do_reset();
        use_mdl = 1'b1;
        for (int cyc = 0; cyc < 2000 && wrs < 37; cyc++) begin
            @(negedge clk);
            if (bus.wr_en_o === 1'b1) wrs++;
            bus.inp_valid_i = (sent < 40);
            bus.inp_data_i  = 24'(sent * 256);
            #1;
            if (bus.inp_valid_i && bus.inp_ready_o) sent++;
        end
        bus.inp_valid_i = 1'b0;
        checks++; if (wrs !== 37) begin failures++; $display("FAIL fl_reach got=%0d exp=37", wrs); end
        checks++; if (bus.wr_addr_o !== 6'd36) begin failures++; $display("FAIL fl_pre_addr got=%0d exp=36", bus.wr_addr_o); end
        checks++; if (bus.outstanding_o !== 3'd3) begin failures++; $display("FAIL fl_pre_outstanding got=%0d exp=3", bus.outstanding_o); end
        flush_i = 1'b1;
        #1;
        checks++; if (bus.div_ready_o !== 4'b0000) begin failures++; $display("FAIL fl_div_ready got=%0h exp=0", bus.div_ready_o); end
        checks++; if (bus.inp_ready_o !== 1'b0) begin failures++; $display("FAIL fl_inp_ready got=%0h exp=0", bus.inp_ready_o); end
        @(negedge clk);
        flush_i = 1'b0;
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL fl_busy got=%0h exp=0", bus.busy_o); end
        checks++; if (bus.wr_addr_o !== 6'd0) begin failures++; $display("FAIL fl_addr got=%0d exp=0", bus.wr_addr_o); end
        checks++; if (bus.outstanding_o !== 3'd0) begin failures++; $display("FAIL fl_outstanding got=%0d exp=0", bus.outstanding_o); end
        sent = 0; wrs = 0;
        for (int cyc = 0; cyc < 200 && wrs < 3; cyc++) begin
            @(negedge clk);
            if (bus.wr_en_o === 1'b1) begin
                checks++; if (bus.wr_addr_o !== 6'(wrs)) begin failures++; $display("FAIL fl_new_addr got=%0d exp=%0d", bus.wr_addr_o, wrs); end
                checks++; if (bus.wr_data_o !== 24'(wrs * 128)) begin failures++; $display("FAIL fl_new_data got=%0h exp=%0h", bus.wr_data_o, wrs * 128); end
                wrs++;
            end
            bus.inp_valid_i = (sent < 3);
            bus.inp_data_i  = 24'(sent * 256);
            #1;
            if (bus.inp_valid_i && bus.inp_ready_o) sent++;
        end
        bus.inp_valid_i = 1'b0;
        checks++; if (wrs !== 3) begin failures++; $display("FAIL fl_new_count got=%0d exp=3", wrs); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.inp_valid_i = 1'b0;
        bus.inp_data_i  = '0;
        test_reset();
        test_single_row();
        test_out_of_order();
        test_backpressure();
        test_issue_collect_same_cycle();
        test_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
